// File: rtl/mem_arbiter_if.sv
// Cache-side and RAM-side signals of the memory arbiter.
// slave = arbiter view, master = caches plus RAM view.
interface mem_arbiter_if;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;
    logic        timeout_err;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload,
        output ramREN, ramWEN, ramaddr, ramstore, timeout_err
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload,
        input  ramREN, ramWEN, ramaddr, ramstore, timeout_err
    );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between icache and dcache with burst lock,
// round-robin between transactions and a hung-RAM timeout.
module mem_arbiter #(
    parameter int TIMEOUT   = 64,
    parameter int BURST_MAX = 4
) (
    input logic         CLK,
    input logic         nRST,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, DSERV, ISERV} state_t;

    localparam logic [1:0]  RAM_ACCESS = 2'd2;
    localparam logic [31:0] BAD_WORD   = 32'hBAD1_BAD1;
    localparam logic [7:0]  TMO_LAST   = 8'(TIMEOUT - 1);
    localparam logic [7:0]  BURST_LAST = 8'(BURST_MAX - 1);

    state_t     r_state, w_next;
    logic [7:0] r_tcnt, w_tcnt;
    logic [7:0] r_bcnt, w_bcnt;
    logic       r_last_d, w_last_d;
    logic       r_err;
    logic       w_dreq, w_acc, w_force, w_done;

    assign w_dreq  = bus.dREN | bus.dWEN;
    assign w_acc   = (bus.ramstate == RAM_ACCESS);
    assign w_force = (r_state != IDLE) && !w_acc && (r_tcnt == TMO_LAST);
    assign w_done  = (r_state != IDLE) && (w_acc || w_force);

    assign bus.timeout_err = r_err;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state  <= IDLE;
            r_tcnt   <= '0;
            r_bcnt   <= '0;
            r_last_d <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_tcnt   <= w_tcnt;
            r_bcnt   <= w_bcnt;
            r_last_d <= w_last_d;
            r_err    <= r_err | w_force;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_bcnt       = r_bcnt;
        w_last_d     = r_last_d;
        bus.iwait    = 1'b1;
        bus.dwait    = 1'b1;
        bus.iload    = bus.ramload;
        bus.dload    = bus.ramload;
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        unique case (r_state)
            IDLE: begin
                if (w_dreq && (!bus.iREN || !r_last_d)) begin
                    w_next = DSERV;
                end else if (bus.iREN) begin
                    w_next = ISERV;
                end
            end
            DSERV: begin
                bus.ramaddr  = bus.daddr;
                bus.ramstore = bus.dstore;
                bus.ramWEN   = bus.dWEN;
                bus.ramREN   = !bus.dWEN && bus.dREN;
                bus.dwait    = !w_done;
                if (w_force) bus.dload = BAD_WORD;
                // Completion with the request still up is the next word of a burst
                if (w_done && w_dreq) begin
                    if (bus.iREN && r_bcnt >= BURST_LAST) begin
                        w_next   = ISERV;
                        w_bcnt   = '0;
                        w_last_d = 1'b1;
                    end else if (r_bcnt != 8'hFF) begin
                        w_bcnt = r_bcnt + 8'd1;
                    end
                end else if (!w_dreq) begin
                    w_next   = bus.iREN ? ISERV : IDLE;
                    w_bcnt   = '0;
                    w_last_d = 1'b1;
                end
            end
            ISERV: begin
                bus.ramREN  = 1'b1;
                bus.ramaddr = bus.iaddr;
                bus.iwait   = !w_done;
                if (w_force) bus.iload = BAD_WORD;
                if (w_done) begin
                    w_next   = w_dreq ? DSERV : IDLE;
                    w_last_d = 1'b0;
                end else if (!bus.iREN) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_tcnt = r_tcnt + 8'd1;
        if (r_state == IDLE || w_done || w_next != r_state) w_tcnt = '0;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a small latency-programmable RAM.
// Expected completions are queued in grant order as stimulus is applied.
module tb_mem_arbiter;
    logic CLK = 1'b0;
    logic nRST = 1'b0;

    mem_arbiter_if bus();

    mem_arbiter #(.TIMEOUT(64), .BURST_MAX(4)) dut (
        .CLK (CLK),
        .nRST(nRST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic        isrc;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   lat   = 0;
    bit   stuck = 1'b0;
    int   rcnt  = 0;

    function automatic logic [31:0] rdata(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    assign bus.ramload = rdata(bus.ramaddr);

    always_comb begin
        if (!(bus.ramREN || bus.ramWEN)) bus.ramstate = 2'd0;
        else if (stuck || rcnt < lat)    bus.ramstate = 2'd1;
        else                             bus.ramstate = 2'd2;
    end

    always @(posedge CLK) begin
        if ((bus.ramREN || bus.ramWEN) && bus.ramstate != 2'd2) rcnt <= rcnt + 1;
        else rcnt <= 0;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic push(input logic isrc, input logic wen,
                        input logic [31:0] addr, input logic [31:0] data);
        exp_t e;
        e.isrc = isrc;
        e.wen  = wen;
        e.addr = addr;
        e.data = data;
        sb.push_back(e);
    endtask

    always @(negedge CLK) begin
        if (nRST && (!bus.iwait || !bus.dwait)) begin
            exp_t e;
            chk("excl", 32'(!bus.iwait && !bus.dwait), 32'd0);
            chk("sb_empty", 32'(sb.size() == 0), 32'd0);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("src", 32'(!bus.iwait), 32'(e.isrc));
                chk("addr", bus.ramaddr, e.addr);
                if (e.isrc) begin
                    chk("iload", bus.iload, e.data);
                end else begin
                    chk("dwen", 32'(bus.ramWEN), 32'(e.wen));
                    chk("ddata", e.wen ? bus.ramstore : bus.dload, e.data);
                end
            end
        end
    end

    task automatic wait_done(input bit isrc, input int maxc, output int n);
        bit done;
        n = 0;
        done = 1'b0;
        while (!done && n < maxc) begin
            @(negedge CLK);
            n++;
            done = isrc ? !bus.iwait : !bus.dwait;
        end
        chk(isrc ? "wait_i" : "wait_d", 32'(done), 32'd1);
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        bus.iREN = 1'b0; bus.iaddr = '0;
        bus.dREN = 1'b0; bus.dWEN  = 1'b0;
        bus.daddr = '0;  bus.dstore = '0;
        idle(2);
        nRST = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout t=%0t", $time);
        $fatal(1);
    end

    initial begin
        int n;
        bus.iREN = 1'b0; bus.iaddr = '0;
        bus.dREN = 1'b0; bus.dWEN  = 1'b0;
        bus.daddr = '0;  bus.dstore = '0;
        #12;
        chk("rst_iwait", 32'(bus.iwait), 32'd1);
        chk("rst_dwait", 32'(bus.dwait), 32'd1);
        chk("rst_ren", 32'(bus.ramREN), 32'd0);
        chk("rst_wen", 32'(bus.ramWEN), 32'd0);
        chk("rst_addr", bus.ramaddr, 32'd0);
        chk("rst_err", 32'(bus.timeout_err), 32'd0);
        do_reset();

        // single read, two BUSY cycles before ACCESS
        lat = 2;
        bus.dREN = 1'b1; bus.daddr = 32'h40;
        push(1'b0, 1'b0, 32'h40, rdata(32'h40));
        @(negedge CLK);
        chk("t2_idle_ren", 32'(bus.ramREN), 32'd0);
        @(negedge CLK);
        chk("t2_c1_ren", 32'(bus.ramREN), 32'd1);
        wait_done(1'b0, 10, n);
        chk("t2_lat", 32'(n), 32'd2);
        bus.dREN = 1'b0;
        idle(3);
        chk("t2_idle", 32'(bus.ramREN), 32'd0);

        // two-word write-back, icache held off
        lat = 0;
        bus.dWEN = 1'b1; bus.daddr = 32'h80; bus.dstore = 32'hA;
        push(1'b0, 1'b1, 32'h80, 32'hA);
        push(1'b0, 1'b1, 32'h84, 32'hB);
        push(1'b1, 1'b0, 32'h200, rdata(32'h200));
        idle(1);
        bus.iREN = 1'b1; bus.iaddr = 32'h200;
        wait_done(1'b0, 10, n);
        bus.daddr = 32'h84; bus.dstore = 32'hB;
        wait_done(1'b0, 10, n);
        chk("t3_nobubble", 32'(n), 32'd1);
        bus.dWEN = 1'b0;
        wait_done(1'b1, 10, n);
        bus.iREN = 1'b0;
        idle(3);

        // simultaneous requests out of reset: dcache first
        do_reset();
        lat = 1;
        bus.iREN = 1'b1; bus.iaddr = 32'h300;
        bus.dREN = 1'b1; bus.daddr = 32'h100;
        push(1'b0, 1'b0, 32'h100, rdata(32'h100));
        push(1'b1, 1'b0, 32'h300, rdata(32'h300));
        wait_done(1'b0, 10, n);
        bus.dREN = 1'b0;
        wait_done(1'b1, 10, n);
        bus.iREN = 1'b0;
        idle(3);

        // six-word burst, icache cuts in after four
        lat = 0;
        bus.dWEN = 1'b1; bus.daddr = 32'h1000; bus.dstore = 32'h100;
        bus.iREN = 1'b1; bus.iaddr = 32'h600;
        for (int k = 0; k < 6; k++) begin
            if (k == 4) push(1'b1, 1'b0, 32'h600, rdata(32'h600));
            push(1'b0, 1'b1, 32'h1000 + 32'(4 * k), 32'h100 + 32'(k));
        end
        fork
            begin
                int m;
                for (int k = 0; k < 6; k++) begin
                    wait_done(1'b0, 20, m);
                    if (k < 5) begin
                        bus.daddr  = bus.daddr + 32'd4;
                        bus.dstore = bus.dstore + 32'd1;
                    end else begin
                        bus.dWEN = 1'b0;
                    end
                end
            end
            begin
                int m;
                wait_done(1'b1, 40, m);
                bus.iREN = 1'b0;
            end
        join
        idle(3);
        chk("t5_err", 32'(bus.timeout_err), 32'd0);

        // hung RAM on an icache fetch
        stuck = 1'b1;
        bus.iREN = 1'b1; bus.iaddr = 32'h700;
        push(1'b1, 1'b0, 32'h700, 32'hBAD1_BAD1);
        wait_done(1'b1, 100, n);
        chk("t6_cycles", 32'(n), 32'd65);
        bus.iREN = 1'b0;
        stuck = 1'b0;
        idle(4);
        chk("t6_err_sticky", 32'(bus.timeout_err), 32'd1);

        // reset in the middle of a stalled write
        stuck = 1'b1;
        bus.dWEN = 1'b1; bus.daddr = 32'h500; bus.dstore = 32'h5;
        @(negedge CLK);
        @(negedge CLK);
        chk("t7_wen_on", 32'(bus.ramWEN), 32'd1);
        #2 nRST = 1'b0;
        #1;
        chk("t7_wen_off", 32'(bus.ramWEN), 32'd0);
        chk("t7_ren_off", 32'(bus.ramREN), 32'd0);
        chk("t7_dwait", 32'(bus.dwait), 32'd1);
        chk("t7_addr", bus.ramaddr, 32'd0);
        chk("t7_err_clr", 32'(bus.timeout_err), 32'd0);
        @(posedge CLK);
        #1;
        bus.dWEN = 1'b0;
        stuck = 1'b0;
        nRST = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        chk("t7_idle", 32'(bus.ramWEN | bus.ramREN), 32'd0);

        chk("sb_left", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
